// File: rtl/alu_restoring_divider_pkg.sv
// Shared definitions for the restoring divider coprocessor: FSM encoding and default width.
package alu_restoring_divider_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_restoring_divider_if.sv
// Start/done handshake and operand/result bus between the controller and the divider.
interface alu_restoring_divider_if
    import alu_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/alu_restoring_divider_ripple_sub.sv
// N-bit ripple-carry subtractor a + ~b + 1 built from 1-bit full-adder slices.
module ripple_sub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N:0]   carry;
    logic [N-1:0] b_inv;

    assign carry[0] = 1'b1;
    assign b_inv    = ~b;

    for (genvar i = 0; i < N; i++) begin : g_slice
        logic p;
        assign p          = a[i] ^ b_inv[i];
        assign diff[i]    = p ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv[i]) | (p & carry[i]);
    end

    // Carry-out of 1 means a >= b (no borrow).
    assign no_borrow = carry[N];

endmodule

// File: rtl/alu_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via trial subtraction.
module alu_restoring_divider
    import alu_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_restoring_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   s_d;
    logic [WIDTH:0]   t_d;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic             no_borrow;
    logic             r_top_unused;

    // Shift the next dividend bit into the partial remainder, then trial-subtract the divisor.
    assign s_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    ripple_sub #(.N(WIDTH + 1)) u_sub (
        .a         (s_d),
        .b         ({1'b0, d_q}),
        .diff      (t_d),
        .no_borrow (no_borrow)
    );

    assign r_d = no_borrow ? t_d : s_d;
    assign q_d = {q_q[WIDTH-2:0], no_borrow};

    // R stays below D after every step, so its top bit never feeds the next shift.
    assign r_top_unused = r_q[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            q_q     <= bus.dividend;
                            d_q     <= bus.divisor;
                            r_q     <= '0;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= ST_RUN;
                        end else begin
                            quo_q   <= '1;
                            rem_q   <= bus.dividend;
                            dbz_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quo_q   <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
